// File: rtl/dmem_arbiter_if.sv
//==============================================================================
// dmem_arbiter_if : CPU / DMA / data-memory signal bundle for dmem_arbiter
// Rev 1.0 - initial release
//==============================================================================
`default_nettype none

interface dmem_arbiter_if;
  // CPU MEM-stage side
  logic        cpu_rd;
  logic        cpu_wr;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;

  // DMA side
  logic        dma_req;
  logic        dma_wr;
  logic        dma_last;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic        dma_gnt;
  logic [31:0] dma_rdata;
  logic        dma_rvalid;

  // Single data-memory port
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  // Arbiter view
  modport slave (
    input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  dma_req, dma_wr, dma_last, dma_addr, dma_wdata,
    output dma_gnt, dma_rdata, dma_rvalid,
    output mem_rd, mem_wr, mem_addr, mem_wdata,
    input  mem_rdata
  );

  // Environment view (CPU, DMA engine and memory together)
  modport master (
    output cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output dma_req, dma_wr, dma_last, dma_addr, dma_wdata,
    input  dma_gnt, dma_rdata, dma_rvalid,
    input  mem_rd, mem_wr, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

`default_nettype wire

// File: rtl/dmem_arbiter.sv
//==============================================================================
// dmem_arbiter : CPU/DMA arbiter for one data-memory port, bounded bursts
// Rev 1.0 - initial release
//==============================================================================
`default_nettype none

module dmem_arbiter #(
  parameter int BURST_MAX  = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);

  localparam logic [7:0] C_BURST_LIM  = 8'(BURST_MAX);
  localparam logic [7:0] C_STARVE_LIM = 8'(STARVE_MAX);

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    DMA_BURST = 1'b1
  } state_t;

  state_t      state_q,      state_d;
  logic [7:0]  beat_cnt_q,   beat_cnt_d;
  logic [7:0]  starve_cnt_q, starve_cnt_d;
  logic        dma_rvalid_q, dma_rvalid_d;
  logic [31:0] dma_rdata_q,  dma_rdata_d;

  logic        cpu_req;
  logic        dma_eligible;
  logic        dma_starved;
  logic        cpu_own;
  logic        dma_own;
  logic [7:0]  beat_next;

  // DMA is held off entirely while reset is asserted so a burst cannot resume.
  always_comb begin
    cpu_req      = bus.cpu_rd | bus.cpu_wr;
    dma_eligible = bus.dma_req & rst;
    dma_starved  = dma_eligible & (starve_cnt_q == C_STARVE_LIM);
    cpu_own      = 1'b0;
    dma_own      = 1'b0;
    case (state_q)
      IDLE: begin
        cpu_own = cpu_req & ~dma_starved;
        dma_own = ~cpu_own & dma_eligible;
      end
      DMA_BURST: begin
        dma_own = dma_eligible;
        cpu_own = ~dma_own & cpu_req;
      end
      default: begin
        cpu_own = 1'b0;
        dma_own = 1'b0;
      end
    endcase
  end

  always_comb begin
    bus.mem_rd    = 1'b0;
    bus.mem_wr    = 1'b0;
    bus.mem_addr  = 32'h0;
    bus.mem_wdata = 32'h0;
    if (cpu_own) begin
      bus.mem_wr    = bus.cpu_wr;
      bus.mem_rd    = bus.cpu_rd & ~bus.cpu_wr;
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_wdata;
    end else if (dma_own) begin
      bus.mem_wr    = bus.dma_wr;
      bus.mem_rd    = ~bus.dma_wr;
      bus.mem_addr  = bus.dma_addr;
      bus.mem_wdata = bus.dma_wdata;
    end
  end

  assign bus.cpu_rdata  = bus.mem_rdata;
  assign bus.cpu_stall  = cpu_req & ~cpu_own;
  assign bus.dma_gnt    = dma_own;
  assign bus.dma_rvalid = dma_rvalid_q;
  assign bus.dma_rdata  = dma_rdata_q;

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    beat_next  = beat_cnt_q + 8'd1;
    if (dma_own) begin
      if (bus.dma_last || (beat_next == C_BURST_LIM)) begin
        state_d    = IDLE;
        beat_cnt_d = 8'd0;
      end else begin
        state_d    = DMA_BURST;
        beat_cnt_d = beat_next;
      end
    end else if (state_q == DMA_BURST) begin
      state_d    = IDLE;
      beat_cnt_d = 8'd0;
    end
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!bus.dma_req || dma_own) begin
      starve_cnt_d = 8'd0;
    end else if (starve_cnt_q != C_STARVE_LIM) begin
      starve_cnt_d = starve_cnt_q + 8'd1;
    end
  end

  always_comb begin
    dma_rvalid_d = dma_own & ~bus.dma_wr;
    dma_rdata_d  = dma_rdata_q;
    if (dma_rvalid_d) begin
      dma_rdata_d = bus.mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      beat_cnt_q   <= 8'd0;
      starve_cnt_q <= 8'd0;
      dma_rvalid_q <= 1'b0;
      dma_rdata_q  <= 32'h0;
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      dma_rvalid_q <= dma_rvalid_d;
      dma_rdata_q  <= dma_rdata_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
//==============================================================================
// tb_dmem_arbiter : directed + randomized bench for dmem_arbiter
// Rev 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_dmem_arbiter;

  localparam int C_BURST_MAX  = 8;
  localparam int C_STARVE_MAX = 4;
  localparam int C_OWN_NONE   = 0;
  localparam int C_OWN_CPU    = 1;
  localparam int C_OWN_DMA    = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if bus ();

  dmem_arbiter #(
    .BURST_MAX  (C_BURST_MAX),
    .STARVE_MAX (C_STARVE_MAX)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Environment memory: combinational read, write at the clock edge
  logic [31:0] env_mem [0:63];
  assign bus.mem_rdata = env_mem[bus.mem_addr[7:2]];
  always @(posedge clk) begin
    if (bus.mem_wr) env_mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
  end

  // Reference model state
  logic [31:0] m_mem [0:63];
  bit          m_in_burst = 1'b0;
  int          m_beats    = 0;
  int          m_waited   = 0;
  logic        m_rvalid   = 1'b0;
  logic [31:0] m_rdata    = 32'h0;
  int          m_last_own = C_OWN_NONE;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Who gets the memory this cycle, from the arbitration rules
  function automatic int model_owner(input logic r, input logic crd, input logic cwr, input logic dq);
    bit cpu_wants;
    bit dma_ok;
    cpu_wants = crd | cwr;
    dma_ok    = dq & r;
    if (m_in_burst) begin
      if (dma_ok)         return C_OWN_DMA;
      else if (cpu_wants) return C_OWN_CPU;
      else                return C_OWN_NONE;
    end
    if (cpu_wants && !(dma_ok && m_waited == C_STARVE_MAX)) return C_OWN_CPU;
    if (dma_ok) return C_OWN_DMA;
    return C_OWN_NONE;
  endfunction

  task automatic step(input logic r,
                      input logic crd, input logic cwr,
                      input logic [31:0] ca, input logic [31:0] cwd,
                      input logic dq, input logic dw, input logic dl,
                      input logic [31:0] da, input logic [31:0] dwd);
    int          own;
    logic        e_rd, e_wr;
    logic [31:0] e_addr, e_wdata;
    @(negedge clk);
    check_val("dma_rvalid", {31'h0, bus.dma_rvalid}, {31'h0, m_rvalid});
    check_val("dma_rdata", bus.dma_rdata, m_rdata);
    rst           = r;
    bus.cpu_rd    = crd;
    bus.cpu_wr    = cwr;
    bus.cpu_addr  = ca;
    bus.cpu_wdata = cwd;
    bus.dma_req   = dq;
    bus.dma_wr    = dw;
    bus.dma_last  = dl;
    bus.dma_addr  = da;
    bus.dma_wdata = dwd;
    #1;
    own = model_owner(r, crd, cwr, dq);
    m_last_own = own;
    e_rd = 1'b0; e_wr = 1'b0; e_addr = 32'h0; e_wdata = 32'h0;
    if (own == C_OWN_CPU) begin
      e_wr = cwr; e_rd = crd && !cwr; e_addr = ca; e_wdata = cwd;
    end else if (own == C_OWN_DMA) begin
      e_wr = dw; e_rd = !dw; e_addr = da; e_wdata = dwd;
    end
    check_val("dma_gnt", {31'h0, bus.dma_gnt}, {31'h0, own == C_OWN_DMA});
    check_val("cpu_stall", {31'h0, bus.cpu_stall}, {31'h0, (crd || cwr) && own != C_OWN_CPU});
    check_val("mem_rd", {31'h0, bus.mem_rd}, {31'h0, e_rd});
    check_val("mem_wr", {31'h0, bus.mem_wr}, {31'h0, e_wr});
    check_val("mem_addr", bus.mem_addr, e_addr);
    check_val("mem_wdata", bus.mem_wdata, e_wdata);
    check_val("cpu_rdata", bus.cpu_rdata, m_mem[e_addr[7:2]]);

    // Advance the model to the state after the coming edge
    if (e_wr) m_mem[e_addr[7:2]] = e_wdata;
    if (!r) begin
      m_in_burst = 1'b0; m_beats = 0; m_waited = 0;
      m_rvalid = 1'b0;   m_rdata = 32'h0;
    end else begin
      m_rvalid = (own == C_OWN_DMA) && !dw;
      if (m_rvalid) m_rdata = m_mem[da[7:2]];
      if (own == C_OWN_DMA) begin
        m_beats++;
        if (dl || m_beats == C_BURST_MAX) begin
          m_in_burst = 1'b0; m_beats = 0;
        end else begin
          m_in_burst = 1'b1;
        end
      end else if (m_in_burst) begin
        m_in_burst = 1'b0; m_beats = 0;
      end
      if (!dq || own == C_OWN_DMA) m_waited = 0;
      else if (m_waited < C_STARVE_MAX) m_waited++;
    end
  endtask

  task automatic idle(input logic r);
    step(r, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    int beat;
    int cycles;
    for (int i = 0; i < 64; i++) begin
      env_mem[i] = 32'h0;
      m_mem[i]   = 32'h0;
    end
    bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b0; bus.cpu_addr = 32'h0; bus.cpu_wdata = 32'h0;
    bus.dma_req = 1'b0; bus.dma_wr = 1'b0; bus.dma_last = 1'b0;
    bus.dma_addr = 32'h0; bus.dma_wdata = 32'h0;
    rst = 1'b0;

    repeat (3) idle(1'b0);
    idle(1'b1);

    // Unopposed CPU write then read-back, zero latency
    step(1'b1, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check_val("cpu_wr_pulse", {31'h0, bus.mem_wr}, 32'h1);
    step(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check_val("cpu_readback", bus.cpu_rdata, 32'hDEADBEEF);
    check_val("cpu_no_stall", {31'h0, bus.cpu_stall}, 32'h0);

    // Simultaneous read and write: write wins
    step(1'b1, 1'b1, 1'b1, 32'h20, 32'h12345678, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check_val("rdwr_mem_wr", {31'h0, bus.mem_wr}, 32'h1);
    check_val("rdwr_mem_rd", {31'h0, bus.mem_rd}, 32'h0);

    // Preload, then a 4-beat DMA read ending on dma_last
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b0, 1'b1, 32'h40 + 32'(4 * i), 32'hA5A50000 + 32'(i), 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, (i == 3), 32'h40 + 32'(4 * i), 32'h0);
      check_val("burst4_gnt", {31'h0, bus.dma_gnt}, 32'h1);
    end
    idle(1'b1);
    check_val("burst4_last_data", bus.dma_rdata, 32'hA5A50003);
    idle(1'b1);

    // Starvation: CPU keeps the port until DMA has waited STARVE_MAX cycles
    for (int i = 0; i <= C_STARVE_MAX; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 1'b1, 32'h44, 32'h0);
      check_val("starve_gnt", {31'h0, bus.dma_gnt}, {31'h0, i == C_STARVE_MAX});
    end
    idle(1'b1);

    // 20-beat DMA write burst against a constantly requesting CPU
    beat = 0;
    cycles = 0;
    while (beat < 20 && cycles < 200) begin
      step(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, (beat == 19),
           32'h80 + 32'(4 * (beat % 16)), 32'(beat));
      if (m_last_own == C_OWN_DMA) beat++;
      cycles++;
    end
    check_val("burst20_done", 32'(beat), 32'd20);
    idle(1'b1);

    // Reset during beat 3 abandons the burst
    for (int i = 0; i < 3; i++)
      step((i != 2), (i == 2), 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 1'b0, 32'hC0 + 32'(4 * i), 32'h0);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 1'b0, 32'hC8, 32'h0);
      check_val("rst_no_gnt", {31'h0, bus.dma_gnt}, 32'h0);
      check_val("rst_rvalid", {31'h0, bus.dma_rvalid}, 32'h0);
    end
    idle(1'b1);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      step(1'($urandom_range(0, 63) != 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
           32'($urandom_range(0, 63)) << 2, $urandom,
           1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) == 0),
           32'($urandom_range(0, 63)) << 2, $urandom);
    end
    idle(1'b1);
    idle(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
